// File: rtl/song_sequencer.sv
// song_sequencer: autoplay note source for the piano top level.
// Steps through a 16-entry melody ROM (first phrase of Ode to Joy plus a closing rest)
// at BEAT_CYCLES clocks per beat. Each entry is a LOAD cycle, a SOUND phase and a
// silent GAP phase of GAP_CYCLES, so repeated notes stay audible.
//
// Ports:
//   CLK        in   system clock, all state changes on the rising edge
//   RESET      in   synchronous active-low reset
//   play       in   level, 1 = run, 0 = pause (freezes state, counter and index)
//   restart    in   single-cycle pulse, return to entry 0 (wins over every other event)
//   auto_note  out  registered note code (0 none, 1 C4, 2 D ... 8 C5)
//   note_idx   out  ROM index of the current entry
//   note_start out  one-cycle pulse on the first SOUND cycle of each entry
//   song_wrap  out  one-cycle pulse when the index wraps from 15 to 0
module song_sequencer #(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       play,
    input  logic       restart,
    output logic [3:0] auto_note,
    output logic [3:0] note_idx,
    output logic       note_start,
    output logic       song_wrap
);

    localparam logic [31:0] BeatLen = 32'(BEAT_CYCLES);
    localparam logic [31:0] GapLen  = 32'(GAP_CYCLES);

    typedef enum logic [1:0] {StIdle, StLoad, StSound, StGap} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  note_q, note_d;
    logic [3:0]  auto_note_q, auto_note_d;
    logic        note_start_q, note_start_d;
    logic        song_wrap_q, song_wrap_d;

    logic [5:0]  rom_entry;    // {note[3:0], len[1:0]}, beats = len + 1
    logic [31:0] rom_beats;
    logic [31:0] sound_len;
    logic        expire;

    // Melody ROM
    always_comb begin
        case (idx_q)
            4'd0:  rom_entry = {4'd3, 2'd0};
            4'd1:  rom_entry = {4'd3, 2'd0};
            4'd2:  rom_entry = {4'd4, 2'd0};
            4'd3:  rom_entry = {4'd5, 2'd0};
            4'd4:  rom_entry = {4'd5, 2'd0};
            4'd5:  rom_entry = {4'd4, 2'd0};
            4'd6:  rom_entry = {4'd3, 2'd0};
            4'd7:  rom_entry = {4'd2, 2'd0};
            4'd8:  rom_entry = {4'd1, 2'd0};
            4'd9:  rom_entry = {4'd1, 2'd0};
            4'd10: rom_entry = {4'd2, 2'd0};
            4'd11: rom_entry = {4'd3, 2'd0};
            4'd12: rom_entry = {4'd3, 2'd0};
            4'd13: rom_entry = {4'd2, 2'd0};
            4'd14: rom_entry = {4'd2, 2'd1};
            4'd15: rom_entry = {4'd0, 2'd1};
            default: rom_entry = 6'd0;
        endcase
    end

    assign rom_beats = 32'(rom_entry[1:0]) + 32'd1;
    // Legal parameter ranges keep this at least 1, so no saturation.
    assign sound_len = rom_beats * BeatLen - GapLen;
    // Counter holds the cycles remaining in the current phase, including this one.
    assign expire    = (cnt_q == 32'd1);

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= StIdle;
            cnt_q        <= 32'd0;
            idx_q        <= 4'd0;
            note_q       <= 4'd0;
            auto_note_q  <= 4'd0;
            note_start_q <= 1'b0;
            song_wrap_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            note_q       <= note_d;
            auto_note_q  <= auto_note_d;
            note_start_q <= note_start_d;
            song_wrap_q  <= song_wrap_d;
        end
    end

    // Next-state logic; play=0 simply leaves everything frozen
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        note_d  = note_q;
        if (restart) begin
            idx_d   = 4'd0;
            cnt_d   = 32'd0;
            state_d = play ? StLoad : StIdle;
        end else if (play) begin
            case (state_q)
                StIdle: state_d = StLoad;
                StLoad: begin
                    note_d  = rom_entry[5:2];
                    cnt_d   = sound_len;
                    state_d = StSound;
                end
                StSound: begin
                    if (expire) begin
                        state_d = StGap;
                        cnt_d   = GapLen;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                StGap: begin
                    if (expire) begin
                        state_d = StLoad;
                        cnt_d   = 32'd0;
                        idx_d   = idx_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output logic: values the output registers take on the coming edge
    always_comb begin
        auto_note_d  = 4'd0;
        note_start_d = 1'b0;
        song_wrap_d  = 1'b0;
        if (!restart && play) begin
            case (state_q)
                StLoad: begin
                    // Entering SOUND: the note is not latched yet, take it from the ROM.
                    auto_note_d  = rom_entry[5:2];
                    note_start_d = 1'b1;
                end
                StSound: begin
                    if (!expire) begin
                        auto_note_d = note_q;
                    end
                end
                StGap: song_wrap_d = expire && (idx_q == 4'd15);
                default: ;
            endcase
        end
    end

    assign auto_note  = auto_note_q;
    assign note_idx   = idx_q;
    assign note_start = note_start_q;
    assign song_wrap  = song_wrap_q;

endmodule
